// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/opcode field geometry, the NOP encoding
// and the fetch-stage FSM state encoding.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 6;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/imem_rom.sv
// Instruction memory: synchronous write through the loader port,
// asynchronous (combinational) read for the fetch path.
module imem_rom #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately not reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and instruction memory and drives the
// IF/ID register, honouring redirect > flush > stall > fetch in RUN.
module if_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic              valid,
    output logic              done
);
    import cpu_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  pc_plus4_q, pc_plus4_d;
    logic         valid_q, valid_d;

    logic [31:0]  imem_rdata;
    logic [29:0]  word_idx;
    logic         past_end;

    imem_rom #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (load_en && (state_q == ST_LOAD)),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q[ADDR_W+1:2]),
        .rdata (imem_rdata)
    );

    // End-of-program uses the full word index, not the wrapped memory index.
    assign word_idx = pc_q[31:2];
    assign past_end = word_idx >= {{(30-ADDR_W-1){1'b0}}, prog_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            pc_q       <= 32'd0;
            instr_q    <= NOP_WORD;
            pc_out_q   <= 32'd0;
            pc_plus4_q <= 32'd4;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (start) state_d = ST_RUN;
            ST_RUN:  if (!redirect_en && !flush && !stall && past_end) state_d = ST_DONE;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (state_q == ST_LOAD) begin
            if (start) pc_d = 32'd0;
        end else if (state_q == ST_RUN) begin
            if (redirect_en) begin
                pc_d    = redirect_pc;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else if (flush) begin
                pc_d    = pc_q + 32'd4;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end else if (!stall) begin
                if (past_end) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else begin
                    pc_d       = pc_q + 32'd4;
                    instr_d    = imem_rdata;
                    pc_out_d   = pc_q;
                    pc_plus4_d = pc_q + 32'd4;
                    valid_d    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        done = (state_q == ST_DONE);
    end

    assign instr    = instr_q;
    assign opcode   = opcode_of(instr_q);
    assign pc_out   = pc_out_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule
